// File: rtl/voice_scheduler_if.sv
// Song-event stream from the song reader into the voice scheduler.
// Fields are held stable by the master while ev_valid is high and not yet accepted.
interface voice_scheduler_if #(
  parameter int DUR_WIDTH = 6
);
  logic                 ev_valid;
  logic                 ev_ready;
  logic                 ev_is_advance;
  logic [5:0]           ev_note;
  logic [DUR_WIDTH-1:0] ev_duration;
  logic [1:0]           ev_weight;

  modport master (
    output ev_valid, ev_is_advance, ev_note, ev_duration, ev_weight,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_is_advance, ev_note, ev_duration, ev_weight,
    output ev_ready
  );
endinterface

// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: accepts note/advance events, loads each note into the
// lowest-index free note_player voice and retires it after its duration in beats.
module voice_scheduler #(
  parameter int NUM_VOICES = 3,
  parameter int DUR_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  voice_scheduler_if.slave        ev,
  input  logic                    play,
  input  logic                    beat,
  output logic [NUM_VOICES-1:0]   load_new_note,
  output logic [6*NUM_VOICES-1:0] note_to_load,
  output logic [2*NUM_VOICES-1:0] weight,
  output logic [NUM_VOICES-1:0]   play_enable,
  output logic [NUM_VOICES-1:0]   voice_busy,
  output logic                    idle
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]                             r_state;
  logic [DUR_WIDTH-1:0]                   r_adv_cnt;
  logic [NUM_VOICES-1:0]                  r_busy;
  logic [NUM_VOICES-1:0]                  r_load;
  logic [NUM_VOICES-1:0][5:0]             r_note;
  logic [NUM_VOICES-1:0][1:0]             r_weight;
  logic [NUM_VOICES-1:0][DUR_WIDTH-1:0]   r_remaining;

  logic                  w_tick;
  logic                  w_any_free;
  logic                  w_is_note;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_load_note;
  logic                  w_load_adv;
  logic [NUM_VOICES-1:0] w_grant;

  assign w_tick     = beat & play;
  assign w_any_free = ~&r_busy;

  // Adding one to the busy vector carries through the low run of ones, so ANDing
  // with the inverted vector isolates the lowest free voice as a one-hot grant.
  assign w_grant    = ~r_busy & (r_busy + NUM_VOICES'(1));

  assign w_is_note   = (ev.ev_note != 6'd0) && (ev.ev_duration != '0);
  assign w_ready     = (r_state == ST_RUN) && play &&
                       (ev.ev_is_advance || !w_is_note || w_any_free);
  assign ev.ev_ready = w_ready;

  assign w_accept    = ev.ev_valid & w_ready;
  assign w_load_note = w_accept & ~ev.ev_is_advance & w_is_note;
  assign w_load_adv  = w_accept &  ev.ev_is_advance & (ev.ev_duration != '0);

  // Advance countdown: RUN accepts events, WAIT blocks them for the advance length.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset) begin
      r_state   <= ST_RUN;
      r_adv_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_load_adv) begin
            r_adv_cnt <= ev.ev_duration;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_tick) begin
            r_adv_cnt <= r_adv_cnt - DUR_WIDTH'(1);
            if (r_adv_cnt == DUR_WIDTH'(1)) begin
              r_state <= ST_RUN;
            end
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Per-voice load, countdown and retirement.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the per-voice arrays are only a few flops each and the outputs must read
    // zero out of reset, so they are reset like any other register.
    if (!reset) begin
      r_busy      <= '0;
      r_load      <= '0;
      r_note      <= '0;
      r_weight    <= '0;
      r_remaining <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_load[i] <= w_load_note & w_grant[i];
        if (w_load_note && w_grant[i]) begin
          // A beat on the load edge does not count against the new note.
          r_note[i]      <= ev.ev_note;
          r_weight[i]    <= ev.ev_weight;
          r_remaining[i] <= ev.ev_duration;
          r_busy[i]      <= 1'b1;
        end else if (w_tick && r_busy[i]) begin
          r_remaining[i] <= r_remaining[i] - DUR_WIDTH'(1);
          if (r_remaining[i] == DUR_WIDTH'(1)) begin
            r_busy[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign load_new_note = r_load;
  assign note_to_load  = r_note;
  assign weight        = r_weight;
  assign voice_busy    = r_busy;
  assign play_enable   = r_busy & {NUM_VOICES{play}};
  assign idle          = (r_state == ST_RUN) && !(|r_busy);

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a beat-timestamp model.
module tb_voice_scheduler;

  localparam int NV = 3;
  localparam int DW = 6;

  logic            clk = 1'b0;
  logic            reset;
  logic            play;
  logic            beat;
  logic [NV-1:0]   load_new_note;
  logic [6*NV-1:0] note_to_load;
  logic [2*NV-1:0] weight;
  logic [NV-1:0]   play_enable;
  logic [NV-1:0]   voice_busy;
  logic            idle;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit dut_acc;

  voice_scheduler_if #(.DUR_WIDTH(DW)) ev_if ();

  voice_scheduler #(.NUM_VOICES(NV), .DUR_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .ev            (ev_if),
    .play          (play),
    .beat          (beat),
    .load_new_note (load_new_note),
    .note_to_load  (note_to_load),
    .weight        (weight),
    .play_enable   (play_enable),
    .voice_busy    (voice_busy),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is counted in effective beats (beat && play). Each voice stores the beat
  // count at which it frees; the advance stores the beat count at which WAIT ends.
  int           m_tick;
  int           m_wait_end;
  int           m_end  [NV];
  logic [5:0]   m_note [NV];
  logic [1:0]   m_w    [NV];
  logic [NV-1:0] m_load;

  function automatic logic [NV-1:0] m_busy_vec();
    logic [NV-1:0] b;
    for (int v = 0; v < NV; v++) b[v] = (m_end[v] > m_tick);
    return b;
  endfunction

  function automatic bit m_ready();
    if (m_wait_end > m_tick || !play) return 1'b0;
    if (ev_if.ev_is_advance || ev_if.ev_note == 0 || ev_if.ev_duration == 0) return 1'b1;
    return m_busy_vec() != {NV{1'b1}};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_tick     <= 0;
      m_wait_end <= 0;
      m_load     <= '0;
      for (int v = 0; v < NV; v++) begin
        m_end[v]  <= 0;
        m_note[v] <= '0;
        m_w[v]    <= '0;
      end
    end else begin
      int            nt;
      int            fv;
      bit            acc;
      logic [NV-1:0] busy_now;
      nt       = m_tick + ((beat && play) ? 1 : 0);
      acc      = ev_if.ev_valid && m_ready();
      busy_now = m_busy_vec();
      m_tick  <= nt;
      m_load  <= '0;
      if (acc && ev_if.ev_is_advance && ev_if.ev_duration != 0) begin
        m_wait_end <= nt + int'(ev_if.ev_duration);
      end else if (acc && !ev_if.ev_is_advance && ev_if.ev_note != 0 && ev_if.ev_duration != 0) begin
        fv = -1;
        for (int v = NV - 1; v >= 0; v--) if (!busy_now[v]) fv = v;
        if (fv >= 0) begin
          m_end[fv]  <= nt + int'(ev_if.ev_duration);
          m_note[fv] <= ev_if.ev_note;
          m_w[fv]    <= ev_if.ev_weight;
          m_load[fv] <= 1'b1;
        end
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) dut_acc <= 1'b0;
    else        dut_acc <= ev_if.ev_valid && ev_if.ev_ready;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      logic [NV-1:0]   eb;
      logic [6*NV-1:0] en;
      logic [2*NV-1:0] ew;
      eb = m_busy_vec();
      for (int v = 0; v < NV; v++) begin
        en[6*v +: 6] = m_note[v];
        ew[2*v +: 2] = m_w[v];
      end
      check("load_new_note", load_new_note, m_load);
      check("voice_busy",    voice_busy,    eb);
      check("note_to_load",  note_to_load,  en);
      check("weight",        weight,        ew);
      check("play_enable",   play_enable,   eb & {NV{play}});
      check("idle",          idle,          (m_wait_end <= m_tick) && (eb == '0));
      check("ev_ready",      ev_if.ev_ready, m_ready());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    ev_if.ev_valid = 1'b0;
    beat  = 1'b0;
    play  = 1'b1;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic present(input bit adv, input logic [5:0] note, input logic [DW-1:0] dur,
                         input logic [1:0] w);
    ev_if.ev_is_advance = adv;
    ev_if.ev_note       = note;
    ev_if.ev_duration   = dur;
    ev_if.ev_weight     = w;
    ev_if.ev_valid      = 1'b1;
  endtask

  task automatic wait_accept(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      step();
      if (dut_acc) begin
        ev_if.ev_valid = 1'b0;
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not accepted within %0d cycles", name, budget);
    ev_if.ev_valid = 1'b0;
  endtask

  task automatic send(input bit adv, input logic [5:0] note, input logic [DW-1:0] dur,
                      input logic [1:0] w, input int budget, input string name);
    present(adv, note, dur, w);
    wait_accept(budget, name);
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    step();
    beat = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t1;
    reset = 1'b0;
    play  = 1'b1;
    beat  = 1'b0;
    ev_if.ev_valid      = 1'b0;
    ev_if.ev_is_advance = 1'b0;
    ev_if.ev_note       = '0;
    ev_if.ev_duration   = '0;
    ev_if.ev_weight     = '0;
    #2;
    check("rst_busy", voice_busy, 0);
    check("rst_idle", idle, 1);
    check("rst_note", note_to_load, 0);
    reset_dut();

    // Single note, two beats long.
    send(1'b0, 6'd1, 6'd2, 2'd0, 4, "t1_accept");
    check("t1_load", load_new_note, 3'b001);
    check("t1_note", note_to_load[5:0], 1);
    check("t1_busy", voice_busy, 3'b001);
    step();
    check("t1_load_low", load_new_note, 0);
    pulse_beat();
    check("t1_busy_after_1", voice_busy, 3'b001);
    pulse_beat();
    check("t1_busy_after_2", voice_busy, 0);
    check("t1_idle", idle, 1);

    // Four notes back-to-back into three voices.
    reset_dut();
    send(1'b0, 6'd1, 6'd4, 2'd1, 2, "t2_n1");
    t0 = cyc;
    check("t2_load0", load_new_note, 3'b001);
    send(1'b0, 6'd22, 6'd4, 2'd2, 2, "t2_n22");
    t1 = cyc;
    check("t2_load1", load_new_note, 3'b010);
    check("t2_consec1", t1 - t0, 1);
    send(1'b0, 6'd30, 6'd4, 2'd3, 2, "t2_n30");
    check("t2_load2", load_new_note, 3'b100);
    check("t2_consec2", cyc - t1, 1);
    present(1'b0, 6'd40, 6'd4, 2'd1);
    #1;
    check("t2_ready_blocked", ev_if.ev_ready, 0);
    for (int b = 0; b < 3; b++) begin
      pulse_beat();
      check("t2_still_blocked", ev_if.ev_ready, 0);
    end
    pulse_beat();
    check("t2_all_free", voice_busy, 0);
    check("t2_ready_open", ev_if.ev_ready, 1);
    wait_accept(2, "t2_n40");
    check("t2_load40", load_new_note, 3'b001);
    check("t2_note40", note_to_load[5:0], 40);
    check("t2_voice1_held", note_to_load[11:6], 22);

    // Advance of three beats between two notes.
    reset_dut();
    send(1'b0, 6'd5, 6'd2, 2'd0, 2, "t3_n5");
    send(1'b1, 6'd0, 6'd3, 2'd0, 2, "t3_adv");
    present(1'b0, 6'd9, 6'd1, 2'd2);
    #1;
    check("t3_wait_ready", ev_if.ev_ready, 0);
    check("t3_wait_idle", idle, 0);
    for (int b = 0; b < 3; b++) begin
      pulse_beat();
      check("t3_no_load", load_new_note, 0);
    end
    wait_accept(2, "t3_n9");
    check("t3_load9", load_new_note, 3'b001);
    check("t3_note9", note_to_load[5:0], 9);
    check("t3_weight9", weight[1:0], 2);

    // Pause mid-note: beats while paused do not count.
    reset_dut();
    send(1'b0, 6'd3, 6'd3, 2'd1, 2, "t4_n3");
    pulse_beat();
    play = 1'b0;
    #1;
    check("t4_pe_paused", play_enable, 0);
    pulse_beat();
    pulse_beat();
    check("t4_busy_paused", voice_busy, 3'b001);
    play = 1'b1;
    pulse_beat();
    check("t4_busy_2", voice_busy, 3'b001);
    check("t4_pe_run", play_enable, 3'b001);
    pulse_beat();
    check("t4_done", voice_busy, 0);

    // Rest and zero-length advance are consumed without touching voices.
    reset_dut();
    send(1'b0, 6'd0, 6'd3, 2'd0, 1, "t5_rest");
    check("t5_rest_load", load_new_note, 0);
    send(1'b1, 6'd0, 6'd0, 2'd0, 1, "t5_adv0");
    check("t5_adv0_load", load_new_note, 0);
    check("t5_idle", idle, 1);
    present(1'b0, 6'd7, 6'd1, 2'd0);
    #1;
    check("t5_run_ready", ev_if.ev_ready, 1);
    wait_accept(1, "t5_n7");
    check("t5_load7", load_new_note, 3'b001);

    // Asynchronous reset while all voices busy and in WAIT.
    reset_dut();
    send(1'b0, 6'd11, 6'd9, 2'd1, 2, "t6_a");
    send(1'b0, 6'd12, 6'd9, 2'd2, 2, "t6_b");
    send(1'b0, 6'd13, 6'd9, 2'd3, 2, "t6_c");
    send(1'b1, 6'd0, 6'd5, 2'd0, 2, "t6_adv");
    step();
    check("t6_busy", voice_busy, 3'b111);
    check("t6_not_idle", idle, 0);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_busy", voice_busy, 0);
    check("t6_rst_load", load_new_note, 0);
    check("t6_rst_note", note_to_load, 0);
    check("t6_rst_weight", weight, 0);
    check("t6_rst_pe", play_enable, 0);
    check("t6_rst_idle", idle, 1);
    step();
    reset = 1'b1;
    step();
    check("t6_idle_after", idle, 1);
    present(1'b0, 6'd2, 6'd1, 2'd0);
    #1;
    check("t6_ready_after", ev_if.ev_ready, 1);
    wait_accept(1, "t6_post");

    // Randomized traffic, checked by the per-cycle compare process.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        #2;
        reset = 1'b0;
        ev_if.ev_valid = 1'b0;
        step();
        reset = 1'b1;
      end
      if (ev_if.ev_valid && dut_acc) ev_if.ev_valid = 1'b0;
      if (!ev_if.ev_valid && $urandom_range(0, 99) < 55) begin
        if ($urandom_range(0, 99) < 15) begin
          present(1'b1, 6'($urandom_range(0, 63)), DW'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end else begin
          present(1'b0,
                  ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                  DW'($urandom_range(0, 6)),
                  2'($urandom_range(0, 3)));
        end
      end
      play = ($urandom_range(0, 99) < 93);
      beat = ($urandom_range(0, 99) < 25);
      step();
    end
    ev_if.ev_valid = 1'b0;
    beat = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Sequences and shares a bank of `note_player` voices for polyphonic playback. Consumes a stream of song events (notes and time advances) over a valid/ready handshake, assigns each note to the lowest-index free voice, drives that voice's `load_new_note`/`note_to_load`/`weight`/`play_enable`, and retires the voice after its duration in beats. Sits between the song reader and the `note_player` bank; beat pulses come from `beat_generator`.

## Interface

Parameters:
- `NUM_VOICES`, 3, number of `note_player` instances driven (1..8)
- `DUR_WIDTH`, 6, width of duration and advance counts, in beats

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `play`  in  1  global play/pause; low freezes all timing
- `beat`  in  1  one-cycle pulse per beat
- `ev_valid`  in  1  event present
- `ev_ready`  out  1  event accepted on edge where `ev_valid && ev_ready`
- `ev_is_advance`  in  1  1 = time-advance event, 0 = note event
- `ev_note`  in  6  note number; 0 = rest
- `ev_duration`  in  DUR_WIDTH  note length or advance length, beats
- `ev_weight`  in  2  harmonic weight for the note
- `load_new_note`  out  NUM_VOICES  one-cycle load strobe per voice
- `note_to_load`  out  6*NUM_VOICES  voice i at bits [6i+5:6i]
- `weight`  out  2*NUM_VOICES  voice i at bits [2i+1:2i]
- `play_enable`  out  NUM_VOICES  per-voice enable
- `voice_busy`  out  NUM_VOICES  voice holds an active note
- `idle`  out  1  state RUN and no voice busy

## Operation

- States: RUN (accept events), WAIT (advance countdown). Reset -> RUN.
- `ev_ready` (combinational): state==RUN && `play` && (`ev_is_advance` || `ev_note`==0 || `ev_duration`==0 || any voice free). Event fields must be held stable while `ev_valid` is high and not accepted.
- Accepted note, `ev_note`!=0 and `ev_duration`!=0: v = lowest index with `voice_busy[v]`==0. Register `note_to_load[v]`, `weight[v]`, `remaining[v]`=`ev_duration`, set `voice_busy[v]`, pulse `load_new_note[v]`. Other voices' fields unchanged.
- Accepted rest (`ev_note`==0) or zero-duration note: consumed, no voice touched.
- Accepted advance, `ev_duration`!=0: `adv_cnt`=`ev_duration`, go WAIT. Advance with duration 0: consumed, stay RUN.
- On `beat` && `play`: every busy voice decrements `remaining`; voice with `remaining`==1 clears `voice_busy`. In WAIT, `adv_cnt` decrements; at `adv_cnt`==1 return to RUN.
- `play` low: beats ignored, no acceptance, counters and state frozen; `play_enable` all 0.
- `play_enable[i]` = `voice_busy[i]` && `play` (combinational).
- `note_to_load`/`weight` hold last loaded values after the voice frees.

## Timing

- Reset (async assert, sync release): `load_new_note`=0, `note_to_load`=0, `weight`=0, `voice_busy`=0, `play_enable`=0, `idle`=1, all counters 0, state RUN.
- Note accepted on edge k: `load_new_note[v]`=1 and `voice_busy[v]`=1 during cycle k..k+1 (one cycle); `load_new_note` low after edge k+1.
- Note of duration D accepted: busy through exactly D `beat`-with-`play` pulses following acceptance; cleared at the edge sampling the D-th pulse.
- Acceptance and `beat` on same edge: new voice loads D undecremented; other voices decrement normally.
- Voice freed on edge k is allocatable for an event sampled at edge k+1 (free set from registered `voice_busy`).
- Advance of A beats accepted at edge k: `ev_ready`=0 until the edge sampling the A-th beat; RUN and `ev_ready` possible in the following cycle.
- Back-to-back accepts: one event per cycle max.
- Reset mid-note or mid-WAIT: all voices freed, state RUN immediately.

## Test plan

- Reset, `play`=1, note 1 dur 2 weight 0 -> `load_new_note`=3'b001 for one cycle, `note_to_load[5:0]`=1, `voice_busy[0]` clears on the 2nd beat, `idle`=1 afterwards.
- Four notes (1, 22, 30, 40, dur 4) back-to-back -> voices 0,1,2 loaded on consecutive cycles, `ev_ready`=0 for note 40 until first voice frees, then note 40 lands in voice 0.
- Advance dur 3 between notes 5 and 9 -> note 9 load strobe occurs only after the 3rd beat post-acceptance; `ev_ready`=0 in WAIT.
- `play` dropped for 2 beats mid-note (dur 3) -> `play_enable`=0, beats ignored, note still ends after 3 counted beats once `play`=1.
- Rest event (note 0) and advance dur 0 -> accepted in one cycle each, no `load_new_note`, state stays RUN.
- Async `reset` low while 3 voices busy and in WAIT -> all outputs zero immediately, `idle`=1 after release.
